// File: rtl/wr_fifo_axi_writer_if.sv
// Bus bundle between the frame writer, the show-ahead FIFO read port and the AXI4 write channels.
// master = writer side, slave = FIFO + AXI slave side.
interface wr_fifo_axi_writer_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 28
);
   logic                      fifo_rd_en;
   logic                      fifo_rd_vld;
   logic [DATA_WIDTH-1:0]     fifo_rd_data;

   logic [ADDR_WIDTH-1:0]     axi_awaddr;
   logic [7:0]                axi_awlen;
   logic                      axi_awvalid;
   logic                      axi_awready;

   logic [DATA_WIDTH-1:0]     axi_wdata;
   logic [DATA_WIDTH/8-1:0]   axi_wstrb;
   logic                      axi_wlast;
   logic                      axi_wvalid;
   logic                      axi_wready;

   logic                      axi_bvalid;
   logic                      axi_bready;

   modport master (
      output fifo_rd_en,
      input  fifo_rd_vld,
      input  fifo_rd_data,
      output axi_awaddr,
      output axi_awlen,
      output axi_awvalid,
      input  axi_awready,
      output axi_wdata,
      output axi_wstrb,
      output axi_wlast,
      output axi_wvalid,
      input  axi_wready,
      input  axi_bvalid,
      output axi_bready
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_rd_vld,
      output fifo_rd_data,
      input  axi_awaddr,
      input  axi_awlen,
      input  axi_awvalid,
      output axi_awready,
      input  axi_wdata,
      input  axi_wstrb,
      input  axi_wlast,
      input  axi_wvalid,
      output axi_wready,
      output axi_bvalid,
      input  axi_bready
   );
endinterface

// File: rtl/wr_fifo_axi_writer.sv
// Drains a show-ahead FIFO into AXI4 INCR write bursts, one burst outstanding at a time,
// and pulses frame_done once the last burst of a frame has been acknowledged.
module wr_fifo_axi_writer #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 28,
   parameter int BURST_LEN  = 16,
   parameter int LEN_WIDTH  = 20
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   input  logic                  frame_start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  frame_beats,
   output logic                  busy,
   output logic                  frame_done,
   wr_fifo_axi_writer_if.master  bus
);
   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      DATA = 3'd2,
      RESP = 3'd3,
      DONE = 3'd4
   } state_t;

   // AXI len field for the next burst: min(beats, BURST_LEN) - 1, zero when nothing is left.
   function automatic logic [7:0] awlen_f(input logic [LEN_WIDTH-1:0] beats);
      logic [7:0] len;
      if (beats == {LEN_WIDTH{1'b0}}) begin
         len = 8'd0;
      end else if (beats >= LEN_WIDTH'(BURST_LEN)) begin
         len = 8'(BURST_LEN - 1);
      end else begin
         len = 8'(beats - LEN_WIDTH'(1));
      end
      return len;
   endfunction

   state_t                state_r;
   state_t                state_nxt_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [LEN_WIDTH-1:0]  remain_r;
   logic [7:0]            awlen_r;
   logic [7:0]            beat_cnt_r;

   logic                  frame_accept_s;
   logic                  aw_fire_s;
   logic                  w_fire_s;
   logic                  w_last_s;
   logic [LEN_WIDTH-1:0]  remain_nxt_s;
   logic [ADDR_WIDTH-1:0] burst_bytes_s;

   logic                  awvalid_s;
   logic                  wvalid_s;
   logic                  bready_s;
   logic                  busy_s;
   logic                  frame_done_s;

   assign frame_accept_s = (state_r == IDLE) & frame_start;
   assign aw_fire_s      = awvalid_s & bus.axi_awready;
   assign w_fire_s       = wvalid_s & bus.axi_wready;
   assign w_last_s       = wvalid_s & (beat_cnt_r == awlen_r);
   assign remain_nxt_s   = remain_r - (LEN_WIDTH'(awlen_r) + LEN_WIDTH'(1));
   assign burst_bytes_s  = (ADDR_WIDTH'(awlen_r) + ADDR_WIDTH'(1)) << BYTE_SHIFT;

   // State register.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (frame_start) begin
               if (frame_beats == {LEN_WIDTH{1'b0}}) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = ADDR;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ADDR: begin
            if (aw_fire_s) begin
               state_nxt_s = DATA;
            end else begin
               state_nxt_s = ADDR;
            end
         end
         DATA: begin
            if (w_fire_s & w_last_s) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = DATA;
            end
         end
         RESP: begin
            // remain_r has already been reduced by the burst just written.
            if (bus.axi_bvalid) begin
               if (remain_r == {LEN_WIDTH{1'b0}}) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = ADDR;
               end
            end else begin
               state_nxt_s = RESP;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Output decode; W valid follows the FIFO head combinationally while a burst is open.
   always_comb begin
      awvalid_s    = 1'b0;
      wvalid_s     = 1'b0;
      bready_s     = 1'b0;
      busy_s       = 1'b0;
      frame_done_s = 1'b0;
      case (state_r)
         IDLE: begin
            busy_s = 1'b0;
         end
         ADDR: begin
            busy_s    = 1'b1;
            awvalid_s = 1'b1;
         end
         DATA: begin
            busy_s   = 1'b1;
            wvalid_s = bus.fifo_rd_vld;
         end
         RESP: begin
            busy_s   = 1'b1;
            bready_s = 1'b1;
         end
         DONE: begin
            busy_s       = 1'b1;
            frame_done_s = 1'b1;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Frame bookkeeping: burst address, beats left, current burst length, beat position.
   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         addr_r     <= {ADDR_WIDTH{1'b0}};
         remain_r   <= {LEN_WIDTH{1'b0}};
         awlen_r    <= 8'd0;
         beat_cnt_r <= 8'd0;
      end else begin
         if (frame_accept_s) begin
            addr_r     <= base_addr;
            remain_r   <= frame_beats;
            awlen_r    <= awlen_f(frame_beats);
            beat_cnt_r <= 8'd0;
         end else if (aw_fire_s) begin
            beat_cnt_r <= 8'd0;
         end else if (w_fire_s) begin
            if (w_last_s) begin
               // awlen only moves here, after its burst has left, so it is stable while awvalid.
               remain_r   <= remain_nxt_s;
               addr_r     <= addr_r + burst_bytes_s;
               awlen_r    <= awlen_f(remain_nxt_s);
               beat_cnt_r <= 8'd0;
            end else begin
               beat_cnt_r <= beat_cnt_r + 8'd1;
            end
         end else begin
            beat_cnt_r <= beat_cnt_r;
         end
      end
   end

   assign busy            = busy_s;
   assign frame_done      = frame_done_s;
   assign bus.axi_awvalid = awvalid_s;
   assign bus.axi_awaddr  = addr_r;
   assign bus.axi_awlen   = awlen_r;
   assign bus.axi_wvalid  = wvalid_s;
   assign bus.axi_wdata   = bus.fifo_rd_data;
   assign bus.axi_wstrb   = {(DATA_WIDTH/8){1'b1}};
   assign bus.axi_wlast   = w_last_s;
   assign bus.fifo_rd_en  = w_fire_s;
   assign bus.axi_bready  = bready_s;

endmodule

// File: tb/tb_wr_fifo_axi_writer.sv
// Randomized bench for wr_fifo_axi_writer: bench-side FIFO and AXI slave, a burst/beat level
// reference model checked every cycle, and literal expectations for the directed frames.
module tb_wr_fifo_axi_writer;
   localparam int DW = 128;
   localparam int AW = 28;
   localparam int BL = 16;
   localparam int LW = 20;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } aw_t;

   logic          rd_clk = 1'b0;
   logic          rd_rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] frame_beats = '0;
   logic          busy;
   logic          frame_done;

   wr_fifo_axi_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   wr_fifo_axi_writer #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .LEN_WIDTH(LW)
   ) dut (
      .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .frame_start(frame_start),
      .base_addr(base_addr), .frame_beats(frame_beats),
      .busy(busy), .frame_done(frame_done), .bus(bus)
   );

   always #5 rd_clk = ~rd_clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model state
   aw_t           exp_aw_q[$];
   logic [DW-1:0] exp_w_q[$];
   logic [DW-1:0] fifo_q[$];
   int            w_len_q[$];
   int            beat_idx, b_pending, b_wait, aw_wait_cnt;
   bit            exp_busy, done_due, pop_pend, gate_tgl, gate;

   // Knobs
   int vld_mode = 0;
   int aw_hold  = 0;
   int b_delay  = 0;
   bit rdy_random = 1'b0;

   // Observations of the DUT for the directed literal checks
   aw_t aw_log[$];
   int  wlast_log[$];
   int  aw_cnt, pop_cnt, wlast_cnt, done_cnt, busy_cnt, aw_stall_cnt, bwait_cnt, w_beats;

   task automatic model_reset();
      exp_aw_q.delete(); exp_w_q.delete(); fifo_q.delete(); w_len_q.delete();
      beat_idx = 0; b_pending = 0; b_wait = 0; aw_wait_cnt = 0;
      exp_busy = 1'b0; done_due = 1'b0; pop_pend = 1'b0;
   endtask

   task automatic frame_accept(input logic [AW-1:0] base, input int beats);
      int off;
      int n;
      logic [DW-1:0] d;
      off = 0;
      while (off < beats) begin
         n = (beats - off > BL) ? BL : beats - off;
         exp_aw_q.push_back('{addr: base + AW'(off * (DW / 8)), len: 8'(n - 1)});
         off += n;
      end
      for (int i = 0; i < beats; i++) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         fifo_q.push_back(d);
         exp_w_q.push_back(d);
      end
   endtask

   // Bench FIFO + AXI slave drive at negedge, then sample/compare 1ns later.
   initial begin : monitor
      bit  exp_av, exp_wv, exp_wl, acc, done_nxt;
      aw_t a;
      model_reset();
      forever begin
         @(negedge rd_clk);
         if (pop_pend) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_pend = 1'b0;
         end
         gate_tgl = ~gate_tgl;
         case (vld_mode)
            0:       gate = 1'b1;
            1:       gate = gate_tgl;
            default: gate = ($urandom_range(0, 1) == 1);
         endcase
         bus.fifo_rd_vld  = (fifo_q.size() > 0) && gate;
         bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
         bus.axi_awready  = (aw_wait_cnt >= aw_hold) && (!rdy_random || $urandom_range(0, 1) == 1);
         bus.axi_wready   = !rdy_random || ($urandom_range(0, 3) != 0);
         if (b_pending > 0 && b_wait == 0) begin
            bus.axi_bvalid = 1'b1;
         end else begin
            bus.axi_bvalid = 1'b0;
            if (b_pending > 0) b_wait--;
         end
         #1;
         if (!rd_rst_n) begin
            model_reset();
         end else begin
            exp_av = exp_busy && exp_aw_q.size() > 0 && w_len_q.size() == 0 && b_pending == 0;
            exp_wv = (w_len_q.size() > 0) && bus.fifo_rd_vld;
            exp_wl = exp_wv && (beat_idx == w_len_q[0] - 1);
            check("busy", 128'(busy), 128'(exp_busy));
            check("frame_done", 128'(frame_done), 128'(done_due));
            check("awvalid", 128'(bus.axi_awvalid), 128'(exp_av));
            if (exp_av) begin
               check("awaddr", 128'(bus.axi_awaddr), 128'(exp_aw_q[0].addr));
               check("awlen", 128'(bus.axi_awlen), 128'(exp_aw_q[0].len));
            end
            check("wvalid", 128'(bus.axi_wvalid), 128'(exp_wv));
            check("wlast", 128'(bus.axi_wlast), 128'(exp_wl));
            check("fifo_rd_en", 128'(bus.fifo_rd_en), 128'(exp_wv && bus.axi_wready));
            check("bready", 128'(bus.axi_bready), 128'(b_pending > 0));
            if (exp_wv) begin
               check("wdata", 128'(bus.axi_wdata), 128'(exp_w_q[0]));
               check("wstrb", 128'(bus.axi_wstrb), 128'({(DW/8){1'b1}}));
            end
            // DUT observations
            if (bus.axi_awvalid && bus.axi_awready) begin
               aw_log.push_back('{addr: bus.axi_awaddr, len: bus.axi_awlen});
               aw_cnt++;
            end
            if (bus.axi_awvalid && !bus.axi_awready) aw_stall_cnt++;
            if (bus.fifo_rd_en) pop_cnt++;
            if (bus.axi_wvalid && bus.axi_wready && bus.axi_wlast) begin
               wlast_cnt++;
               wlast_log.push_back(w_beats + 1);
            end
            if (busy) busy_cnt++;
            if (frame_done) done_cnt++;
            if (bus.axi_bready && !bus.axi_bvalid) bwait_cnt++;
            if (bus.fifo_rd_en && bus.fifo_rd_vld) pop_pend = 1'b1;
            // Model advance
            done_nxt = 1'b0;
            if (b_pending > 0 && bus.axi_bvalid) begin
               b_pending--;
               if (b_pending == 0 && exp_aw_q.size() == 0 && w_len_q.size() == 0) done_nxt = 1'b1;
            end
            if (exp_av && bus.axi_awready) begin
               a = exp_aw_q.pop_front();
               w_len_q.push_back(int'(a.len) + 1);
               beat_idx = 0;
               aw_wait_cnt = 0;
            end else if (exp_av) begin
               aw_wait_cnt++;
            end
            if (exp_wv && bus.axi_wready) begin
               w_beats++;
               if (exp_w_q.size() > 0) void'(exp_w_q.pop_front());
               beat_idx++;
               if (beat_idx == w_len_q[0]) begin
                  void'(w_len_q.pop_front());
                  beat_idx = 0;
                  b_pending++;
                  b_wait = rdy_random ? int'($urandom_range(0, 3)) : b_delay;
               end
            end
            acc = frame_start && !exp_busy;
            if (done_due) exp_busy = 1'b0;
            if (acc) begin
               exp_busy = 1'b1;
               frame_accept(base_addr, int'(frame_beats));
               if (frame_beats == '0) done_nxt = 1'b1;
            end
            done_due = done_nxt;
         end
      end
   end

   task automatic clear_stats();
      @(posedge rd_clk);
      aw_log.delete(); wlast_log.delete();
      aw_cnt = 0; pop_cnt = 0; wlast_cnt = 0; done_cnt = 0; busy_cnt = 0;
      aw_stall_cnt = 0; bwait_cnt = 0; w_beats = 0;
   endtask

   task automatic set_knobs(input int vm, input int ah, input int bd, input bit rr);
      @(posedge rd_clk);
      vld_mode = vm; aw_hold = ah; b_delay = bd; rdy_random = rr;
   endtask

   task automatic start_frame(input logic [AW-1:0] base, input int beats);
      @(negedge rd_clk);
      frame_start = 1'b1;
      base_addr   = base;
      frame_beats = LW'(beats);
      @(negedge rd_clk);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int start;
      start = done_cnt;
      for (int i = 0; i < budget; i++) begin
         @(negedge rd_clk);
         if (done_cnt != start) break;
      end
      check("frame_timeout", 128'(done_cnt != start), 128'(1));
      repeat (3) @(negedge rd_clk);
   endtask

   initial begin : stimulus
      logic [AW-1:0] rb;
      repeat (3) @(negedge rd_clk);
      #2;
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_awvalid", 128'(bus.axi_awvalid), 128'(0));
      check("rst_awaddr", 128'(bus.axi_awaddr), 128'(0));
      check("rst_awlen", 128'(bus.axi_awlen), 128'(0));
      check("rst_wvalid", 128'(bus.axi_wvalid), 128'(0));
      check("rst_bready", 128'(bus.axi_bready), 128'(0));
      @(negedge rd_clk);
      rd_rst_n = 1'b1;

      // 40-beat frame, everything ready
      set_knobs(0, 0, 0, 1'b0);
      clear_stats();
      start_frame(28'h0000100, 40);
      wait_done(500);
      check("t1_aw_cnt", 128'(aw_cnt), 128'(3));
      check("t1_aw0_addr", 128'(aw_log[0].addr), 128'(28'h0000100));
      check("t1_aw0_len", 128'(aw_log[0].len), 128'(15));
      check("t1_aw1_addr", 128'(aw_log[1].addr), 128'(28'h0000200));
      check("t1_aw1_len", 128'(aw_log[1].len), 128'(15));
      check("t1_aw2_addr", 128'(aw_log[2].addr), 128'(28'h0000300));
      check("t1_aw2_len", 128'(aw_log[2].len), 128'(7));
      check("t1_pops", 128'(pop_cnt), 128'(40));
      check("t1_wlast_cnt", 128'(wlast_cnt), 128'(3));
      check("t1_wlast_a", 128'(wlast_log[0]), 128'(16));
      check("t1_wlast_b", 128'(wlast_log[1]), 128'(32));
      check("t1_wlast_c", 128'(wlast_log[2]), 128'(40));
      check("t1_done_cnt", 128'(done_cnt), 128'(1));

      // Empty frame
      clear_stats();
      start_frame(28'h0000400, 0);
      wait_done(20);
      check("t2_aw_cnt", 128'(aw_cnt), 128'(0));
      check("t2_pops", 128'(pop_cnt), 128'(0));
      check("t2_busy_cycles", 128'(busy_cnt), 128'(1));
      check("t2_done_cnt", 128'(done_cnt), 128'(1));

      // FIFO valid toggling
      set_knobs(1, 0, 0, 1'b0);
      clear_stats();
      start_frame(28'h0001000, 16);
      wait_done(200);
      check("t3_pops", 128'(pop_cnt), 128'(16));
      check("t3_wlast_cnt", 128'(wlast_cnt), 128'(1));
      check("t3_wlast_pos", 128'(wlast_log[0]), 128'(16));

      // awready held low
      set_knobs(0, 10, 0, 1'b0);
      clear_stats();
      start_frame(28'h0002000, 16);
      wait_done(200);
      check("t4_aw_stall", 128'(aw_stall_cnt), 128'(10));
      check("t4_aw_addr", 128'(aw_log[0].addr), 128'(28'h0002000));

      // Late B response, start pulsed while busy
      set_knobs(0, 0, 20, 1'b0);
      clear_stats();
      start_frame(28'h0003000, 32);
      repeat (5) @(negedge rd_clk);
      start_frame(28'h0005000, 3);
      wait_done(300);
      check("t5_aw_cnt", 128'(aw_cnt), 128'(2));
      check("t5_aw1_addr", 128'(aw_log[1].addr), 128'(28'h0003100));
      check("t5_b_wait", 128'(bwait_cnt), 128'(40));
      check("t5_done_cnt", 128'(done_cnt), 128'(1));

      // Reset in the middle of a burst
      set_knobs(0, 0, 0, 1'b0);
      clear_stats();
      start_frame(28'h0006000, 40);
      for (int i = 0; i < 200; i++) begin
         @(negedge rd_clk);
         #2;
         if (w_beats >= 5) break;
      end
      check("t6_reach_beat5", 128'(w_beats >= 5), 128'(1));
      @(posedge rd_clk);
      #2;
      rd_rst_n = 1'b0;
      #1;
      check("t6_busy", 128'(busy), 128'(0));
      check("t6_awvalid", 128'(bus.axi_awvalid), 128'(0));
      check("t6_wvalid", 128'(bus.axi_wvalid), 128'(0));
      check("t6_wlast", 128'(bus.axi_wlast), 128'(0));
      check("t6_rd_en", 128'(bus.fifo_rd_en), 128'(0));
      check("t6_awaddr", 128'(bus.axi_awaddr), 128'(0));
      repeat (2) @(negedge rd_clk);
      rd_rst_n = 1'b1;
      clear_stats();
      start_frame(28'h0007000, 20);
      wait_done(300);
      check("t6_aw0_addr", 128'(aw_log[0].addr), 128'(28'h0007000));
      check("t6_aw1_addr", 128'(aw_log[1].addr), 128'(28'h0007100));
      check("t6_aw1_len", 128'(aw_log[1].len), 128'(3));
      check("t6_pops", 128'(pop_cnt), 128'(20));

      // Random back-pressure, including an address wrap
      set_knobs(2, 0, 0, 1'b1);
      clear_stats();
      start_frame(28'hFFFFF00, 40);
      wait_done(3000);
      check("t7_wrap_addr", 128'(aw_log[1].addr), 128'(28'h0000000));
      check("t7_wrap_pops", 128'(pop_cnt), 128'(40));
      for (int f = 0; f < 5; f++) begin
         rb = AW'($urandom) & ~AW'(28'hFF);
         start_frame(rb, int'($urandom_range(1, 80)));
         wait_done(3000);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
